pong_match_ctrl: RTL
====================

Name: pong_match_ctrl

Overview:
Match-flow controller for the Pong mode. Sequences the ball and score datapath through idle, serve countdown, rally, point pause and game-over phases. Owns both player scores. Drives ball run/recentre controls, the seven-segment/OLED status fields and the winner flag. Sits between the mode gate (sw[0] && flag) and the ball/score/paddle blocks, on the same 6.25 MHz-class game clock.

Parameters:
WIN_SCORE, 7, points needed to win (1..15)
SERVE_TICKS, 20, frame ticks per countdown step
POINT_TICKS, 30, frame ticks of post-point pause
CNT_W, 6, width of tick timer (must hold max(SERVE_TICKS, POINT_TICKS))

Ports:
clk  in  1  game clock; all state on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
tick  in  1  one-cycle frame strobe; all timing counts ticks
E  in  1  Pong mode active
start  in  1  serve/restart request, level (btnU), edge-detected internally
p1_pt  in  1  one-cycle pulse, left player scored
p2_pt  in  1  one-cycle pulse, right player scored
ball_run  out  1  ball may move
ball_rst  out  1  one-cycle pulse, recentre ball
serve_dir  out  1  0 = serve toward left, 1 = toward right
p1_score  out  4  left score
p2_score  out  4  right score
countdown  out  2  serve digit 3..1, 0 otherwise
flash  out  1  point/game-over blink for OLED
game_over  out  1  match finished
winner  out  1  0 = left, 1 = right; valid when game_over

Behaviour:
- Reset (rst=0, async): state IDLE; scores 0; timer 0; countdown 0; serve_dir 0; ball_run, ball_rst, flash, game_over, winner all 0; start edge register 0.
- States: IDLE, SERVE, RALLY, POINT, OVER. Encoding in package.
- E=0 in any state: next cycle -> IDLE, scores cleared, outputs as reset. Overrides all other events.
- IDLE: on start rising edge (start=1, previous sample 0) -> SERVE, countdown=3, timer=SERVE_TICKS, ball_rst pulses 1 cycle.
- SERVE: ball_run=0. Timer decrements on tick. At tick with timer==1: if countdown>1 then countdown-1, timer reload; else countdown=0 -> RALLY. Total serve = 3*SERVE_TICKS ticks.
- RALLY: ball_run=1. p1_pt alone: p1_score+1, serve_dir=1 (toward loser, right). p2_pt alone: p2_score+1, serve_dir=0. Either -> POINT, timer=POINT_TICKS, ball_run drops same edge. p1_pt and p2_pt in same cycle: no score change, -> POINT (replay), serve_dir unchanged. Points outside RALLY are ignored.
- POINT: ball_run=0; flash toggles every 4 ticks. On timer expiry: if either score == WIN_SCORE -> OVER, winner = scorer, game_over=1; else -> SERVE with countdown=3, ball_rst pulse.
- OVER: game_over=1, flash toggles every 8 ticks, scores held. start rising edge -> scores 0, game_over=0, -> SERVE, ball_rst pulse, serve_dir=0.
- Score arithmetic 4-bit unsigned; a score never exceeds WIN_SCORE (compare on incremented value).
- start held high through a transition does not retrigger; a new rising edge is required.
- tick and state edge coincide: tick is consumed in the state current at that edge.
- Outputs registered; ball_rst is exactly one clk cycle wide.

Decomposition:
- Package pong_pkg: state encoding (IDLE=0, SERVE=1, RALLY=2, POINT=3, OVER=4, 3-bit), default WIN_SCORE/SERVE_TICKS/POINT_TICKS constants, colour defines already shared.
- One sub-module: tick_timer (loadable down-counter, decrements on tick, done pulse when 1->0, width CNT_W).

Test Plan:
- rst=0 mid-RALLY with scores 3/2 -> all outputs 0 immediately, state IDLE before next edge.
- E=1, start pulse, SERVE_TICKS=2 -> ball_rst 1 cycle, countdown 3,2,1 each 2 ticks, ball_run=1 after 6th tick.
- RALLY, p2_pt pulse -> p2_score=1, serve_dir=0, ball_run=0 next edge, SERVE re-entered after POINT_TICKS ticks.
- p1_pt and p2_pt same cycle -> scores unchanged, POINT then SERVE.
- WIN_SCORE=3, p1 scores 3 times -> game_over=1, winner=0, p1_score=3; start edge -> scores 0, SERVE.
- E dropped during POINT with score 5/4 -> IDLE, scores 0; p1_pt in IDLE/SERVE -> no change.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared Pong-mode definitions: match FSM encoding, default timing constants,
// shared colour constants and a saturating score helper.
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    RALLY = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam int unsigned DEF_WIN_SCORE   = 7;
  localparam int unsigned DEF_SERVE_TICKS = 20;
  localparam int unsigned DEF_POINT_TICKS = 30;
  localparam int unsigned DEF_CNT_W       = 6;

  localparam logic [1:0] SERVE_STEPS = 2'd3;

  localparam logic [11:0] COLOUR_BG     = 12'h000;
  localparam logic [11:0] COLOUR_BALL   = 12'hFFF;
  localparam logic [11:0] COLOUR_LEFT   = 12'h0F0;
  localparam logic [11:0] COLOUR_RIGHT  = 12'hF00;

  // Increment only when the result stays within the limit; widened so 15 cannot wrap.
  function automatic logic [3:0] sat_inc(input logic [3:0] score, input logic [3:0] limit);
    logic [4:0] inc;
    inc = {1'b0, score} + 5'd1;
    return (inc > {1'b0, limit}) ? score : inc[3:0];
  endfunction

endpackage

// File: rtl/pong_match_ctrl_tick_timer.sv
// Loadable tick down-counter; done flags the tick that takes the count from 1 to 0.
module tick_timer #(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (tick && count != '0)
      count <= count - 1'b1;
  end

  assign done = tick && (count == CNT_W'(1));

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match-flow controller: serve countdown, rally, point pause and game-over,
// owning both scores and driving the ball run/recentre controls.
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned WIN_SCORE   = DEF_WIN_SCORE,
  parameter int unsigned SERVE_TICKS = DEF_SERVE_TICKS,
  parameter int unsigned POINT_TICKS = DEF_POINT_TICKS,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       E,
  input  logic       start,
  input  logic       p1_pt,
  input  logic       p2_pt,
  output logic       ball_run,
  output logic       ball_rst,
  output logic       serve_dir,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [1:0] countdown,
  output logic       flash,
  output logic       game_over,
  output logic       winner
);

  localparam logic [CNT_W-1:0] SERVE_LOAD = CNT_W'(SERVE_TICKS);
  localparam logic [CNT_W-1:0] POINT_LOAD = CNT_W'(POINT_TICKS);
  localparam logic [3:0]       WIN4       = 4'(WIN_SCORE);

  state_t     state, state_next;
  logic       start_q, start_edge;
  logic [2:0] flash_cnt, flash_cnt_next;
  logic [3:0] p1_next, p2_next;
  logic [1:0] cd_next;
  logic       dir_next, ball_rst_next, flash_next, winner_next;
  logic       load, done;
  logic [CNT_W-1:0] load_val;

  assign start_edge = start && !start_q;

  tick_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst),
    .tick     (tick),
    .load     (load),
    .load_val (load_val),
    .done     (done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      start_q   <= 1'b0;
      flash_cnt <= '0;
      p1_score  <= '0;
      p2_score  <= '0;
      countdown <= '0;
      serve_dir <= 1'b0;
      ball_run  <= 1'b0;
      ball_rst  <= 1'b0;
      flash     <= 1'b0;
      game_over <= 1'b0;
      winner    <= 1'b0;
    end else begin
      state     <= state_next;
      start_q   <= start;
      flash_cnt <= flash_cnt_next;
      p1_score  <= p1_next;
      p2_score  <= p2_next;
      countdown <= cd_next;
      serve_dir <= dir_next;
      ball_run  <= (state_next == RALLY);
      ball_rst  <= ball_rst_next;
      flash     <= flash_next;
      game_over <= (state_next == OVER);
      winner    <= winner_next;
    end
  end

  always_comb begin
    state_next     = state;
    p1_next        = p1_score;
    p2_next        = p2_score;
    cd_next        = countdown;
    dir_next       = serve_dir;
    ball_rst_next  = 1'b0;
    flash_next     = flash;
    flash_cnt_next = flash_cnt;
    winner_next    = winner;
    load           = 1'b0;
    load_val       = '0;

    unique case (state)
      IDLE: begin
        if (start_edge) begin
          state_next    = SERVE;
          cd_next       = SERVE_STEPS;
          load          = 1'b1;
          load_val      = SERVE_LOAD;
          ball_rst_next = 1'b1;
        end
      end
      SERVE: begin
        if (done) begin
          if (countdown > 2'd1) begin
            cd_next  = countdown - 2'd1;
            load     = 1'b1;
            load_val = SERVE_LOAD;
          end else begin
            cd_next    = '0;
            state_next = RALLY;
          end
        end
      end
      RALLY: begin
        if (p1_pt || p2_pt) begin
          state_next     = POINT;
          load           = 1'b1;
          load_val       = POINT_LOAD;
          flash_next     = 1'b0;
          flash_cnt_next = '0;
          // Simultaneous points are a replay: no score or serve change.
          if (p1_pt && !p2_pt) begin
            p1_next  = sat_inc(p1_score, WIN4);
            dir_next = 1'b1;
          end else if (p2_pt && !p1_pt) begin
            p2_next  = sat_inc(p2_score, WIN4);
            dir_next = 1'b0;
          end
        end
      end
      POINT: begin
        if (tick) begin
          flash_cnt_next = flash_cnt + 3'd1;
          if (flash_cnt[1:0] == 2'b11)
            flash_next = ~flash;
        end
        if (done) begin
          flash_cnt_next = '0;
          flash_next     = 1'b0;
          if (p1_score == WIN4 || p2_score == WIN4) begin
            state_next  = OVER;
            winner_next = (p2_score == WIN4);
          end else begin
            state_next    = SERVE;
            cd_next       = SERVE_STEPS;
            load          = 1'b1;
            load_val      = SERVE_LOAD;
            ball_rst_next = 1'b1;
          end
        end
      end
      OVER: begin
        if (tick) begin
          flash_cnt_next = flash_cnt + 3'd1;
          if (flash_cnt == 3'b111)
            flash_next = ~flash;
        end
        if (start_edge) begin
          state_next     = SERVE;
          p1_next        = '0;
          p2_next        = '0;
          dir_next       = 1'b0;
          cd_next        = SERVE_STEPS;
          load           = 1'b1;
          load_val       = SERVE_LOAD;
          ball_rst_next  = 1'b1;
          flash_next     = 1'b0;
          flash_cnt_next = '0;
          winner_next    = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase

    // Leaving Pong mode wins over every other event and restores the reset picture.
    if (!E) begin
      state_next     = IDLE;
      p1_next        = '0;
      p2_next        = '0;
      cd_next        = '0;
      dir_next       = 1'b0;
      ball_rst_next  = 1'b0;
      flash_next     = 1'b0;
      flash_cnt_next = '0;
      winner_next    = 1'b0;
      load           = 1'b1;
      load_val       = '0;
    end
  end

endmodule
